load_store_unit: RTL and testbench

Memory-access stage that serves the load path of the decode stage and issues its stores. It takes one decoded load/store request (base register, 12-bit immediate, funct3, store data) and runs a request/grant/response transaction on the data-memory bus. It returns the extracted and extended load data plus a one-cycle regfile write-enable pulse. One transaction is in flight at a time; misaligned or illegal accesses and bus timeouts are flagged without corrupting state.

---
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one decoded load/store request, runs a single
// request/grant/response transaction on the data-memory bus, and returns
// extended load data with a one-cycle completion and writeback pulse.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        load_en_i,
   input  logic        store_en_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] rs1_data_i,
   input  logic [11:0] imm_i,
   input  logic [31:0] store_data_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] load_data_o,
   output logic        done_o,
   output logic        wb_en_o,
   output logic        err_o
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] REQ       = 2'd1;
   localparam logic [1:0] WAIT_RESP = 2'd2;

   localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
   localparam bit               TIMEOUT_ON  = (TIMEOUT_CYCLES != 0);

   logic [1:0]       state;
   logic             is_load;
   logic [2:0]       size_sign;
   logic [1:0]       ea_low;
   logic [CNT_W-1:0] cnt;

   logic [31:0] ea;
   logic        accept;
   logic        req_load;
   logic        f3_legal;
   logic        misaligned;
   logic        req_bad;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;

   assign req_ready_o = (state == IDLE);

   // Request decode: effective address, legality, byte enables and lane-replicated write data
   always_comb begin
      ea       = rs1_data_i + {{20{imm_i[11]}}, imm_i};
      req_load = load_en_i;
      accept   = req_valid_i & (state == IDLE) & (load_en_i | store_en_i);

      case (funct3_i)
         3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
         3'b100, 3'b101:         f3_legal = req_load;
         default:                f3_legal = 1'b0;
      endcase

      case (funct3_i[1:0])
         2'b01:   misaligned = ea[0];
         2'b10:   misaligned = (ea[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase

      req_bad = ~f3_legal | misaligned;

      case (funct3_i[1:0])
         2'b00: begin
            be_next    = 4'b0001 << ea[1:0];
            wdata_next = {4{store_data_i[7:0]}};
         end
         2'b01: begin
            be_next    = ea[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{store_data_i[15:0]}};
         end
         default: begin
            be_next    = 4'b1111;
            wdata_next = store_data_i;
         end
      endcase

      if (req_load) wdata_next = '0;
   end

   // Lane selection and sign/zero extension of the returned read word
   always_comb begin
      case (ea_low)
         2'd0:    byte_sel = mem_rdata_i[7:0];
         2'd1:    byte_sel = mem_rdata_i[15:8];
         2'd2:    byte_sel = mem_rdata_i[23:16];
         default: byte_sel = mem_rdata_i[31:24];
      endcase
      half_sel = ea_low[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

      case (size_sign)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_ext = {24'd0, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_ext = {16'd0, half_sel};
         default: load_ext = mem_rdata_i;
      endcase
   end

   // Transaction FSM, registered bus outputs and completion pulses
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= IDLE;
         is_load     <= 1'b0;
         size_sign   <= '0;
         ea_low      <= '0;
         cnt         <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_be_o    <= '0;
         mem_wdata_o <= '0;
         load_data_o <= '0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         wb_en_o     <= 1'b0;
      end else begin
         done_o  <= 1'b0;
         err_o   <= 1'b0;
         wb_en_o <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  is_load   <= req_load;
                  size_sign <= funct3_i;
                  ea_low    <= ea[1:0];
                  if (req_bad) begin
                     done_o <= 1'b1;
                     err_o  <= 1'b1;
                  end else begin
                     state       <= REQ;
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= ~req_load;
                     mem_addr_o  <= {ea[31:2], 2'b00};
                     mem_be_o    <= be_next;
                     mem_wdata_o <= wdata_next;
                  end
               end
            end
            REQ: begin
               if (mem_gnt_i) begin
                  state     <= WAIT_RESP;
                  mem_req_o <= 1'b0;
                  cnt       <= '0;
               end
            end
            WAIT_RESP: begin
               if (mem_rvalid_i) begin
                  state  <= IDLE;
                  done_o <= 1'b1;
                  if (is_load) begin
                     wb_en_o     <= 1'b1;
                     load_data_o <= load_ext;
                  end
               end else if (TIMEOUT_ON && ((cnt + CNT_W'(1)) == TIMEOUT_LIM)) begin
                  state  <= IDLE;
                  done_o <= 1'b1;
                  err_o  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: table of request vectors with a scoreboard
// of expected completions, plus sequences for timeout, unaccepted requests
// and reset during a transaction.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic        load_en, store_en;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic [11:0] imm;
   logic [31:0] store_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic [31:0] load_data;
   logic        done, wb_en, err;

   load_store_unit #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .load_en_i(load_en), .store_en_i(store_en), .funct3_i(funct3),
      .rs1_data_i(rs1_data), .imm_i(imm), .store_data_i(store_data),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
      .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
      .load_data_o(load_data), .done_o(done), .wb_en_o(wb_en), .err_o(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          ld;
      bit          st;
      logic [2:0]  f3;
      logic [31:0] rs1;
      logic [11:0] imm;
      logic [31:0] sdata;
      logic [31:0] rdata;
      int          gdly;
      bit          err;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      bit          wb;
      logic [31:0] ldata;
   } vec_t;

   typedef struct {
      bit          err;
      bit          wb;
      logic [31:0] ldata;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_total++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, want);
   endtask

   // Scoreboard: every completion pulse is matched against the oldest expectation
   always @(negedge clk) begin
      if (rst_n && done === 1'b1) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL done_unexpected: got done=1, want no completion");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_err", {31'd0, err}, {31'd0, e.err});
            check("sb_wb_en", {31'd0, wb_en}, {31'd0, e.wb});
            check("sb_load_data", load_data, e.ldata);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      exp_t e;
      req_valid  = 1'b1;
      load_en    = v.ld;
      store_en   = v.st;
      funct3     = v.f3;
      rs1_data   = v.rs1;
      imm        = v.imm;
      store_data = v.sdata;
      e.err = v.err; e.wb = v.wb; e.ldata = v.ldata;
      sb.push_back(e);
      step();
      req_valid = 1'b0; load_en = 1'b0; store_en = 1'b0;
      if (v.err) begin
         check($sformatf("v%0d_no_req", idx), {31'd0, mem_req}, 32'd0);
         check($sformatf("v%0d_err_done_next", idx), {31'd0, done}, 32'd1);
         check($sformatf("v%0d_ready_kept", idx), {31'd0, req_ready}, 32'd1);
      end else begin
         check($sformatf("v%0d_req", idx), {31'd0, mem_req}, 32'd1);
         check($sformatf("v%0d_we", idx), {31'd0, mem_we}, {31'd0, ~v.ld});
         check($sformatf("v%0d_addr", idx), mem_addr, v.addr);
         check($sformatf("v%0d_be", idx), {28'd0, mem_be}, {28'd0, v.be});
         check($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
         check($sformatf("v%0d_busy", idx), {31'd0, req_ready}, 32'd0);
         for (int s = 0; s < v.gdly; s++) begin
            step();
            check($sformatf("v%0d_stall%0d", idx, s),
                  {mem_req, 3'd0, mem_be, mem_addr[23:0]},
                  {1'b1, 3'd0, v.be, v.addr[23:0]});
         end
         mem_gnt = 1'b1;
         step();
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b1;
         mem_rdata  = v.rdata;
         step();
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         check($sformatf("v%0d_done_latency", idx), {31'd0, done}, 32'd1);
         check($sformatf("v%0d_req_dropped", idx), {31'd0, mem_req}, 32'd0);
      end
   endtask

   vec_t vecs[15];

   initial begin
      // ld st f3 rs1 imm sdata rdata gdly err addr be wdata wb ldata
      vecs[0]  = '{1, 0, 3'b010, 32'h0000_1000, 12'h004, 32'h0, 32'hDEAD_BEEF, 0, 0, 32'h0000_1004, 4'hF, 32'h0, 1, 32'hDEAD_BEEF};
      vecs[1]  = '{1, 0, 3'b000, 32'h0000_1000, 12'h003, 32'h0, 32'h80FF_0000, 0, 0, 32'h0000_1000, 4'h8, 32'h0, 1, 32'hFFFF_FF80};
      vecs[2]  = '{1, 0, 3'b100, 32'h0000_1000, 12'h003, 32'h0, 32'h80FF_0000, 1, 0, 32'h0000_1000, 4'h8, 32'h0, 1, 32'h0000_0080};
      vecs[3]  = '{0, 1, 3'b001, 32'h0000_2000, 12'h002, 32'h1234_ABCD, 32'h5555_5555, 0, 0, 32'h0000_2000, 4'hC, 32'hABCD_ABCD, 0, 32'h0000_0080};
      vecs[4]  = '{1, 0, 3'b001, 32'h0000_3000, 12'hFFE, 32'h0, 32'h8001_1234, 0, 0, 32'h0000_2FFC, 4'hC, 32'h0, 1, 32'hFFFF_8001};
      vecs[5]  = '{1, 0, 3'b101, 32'h0FFF_FFFF, 12'h7FF, 32'h0, 32'hF00D_BEEF, 0, 0, 32'h1000_07FC, 4'hC, 32'h0, 1, 32'h0000_F00D};
      vecs[6]  = '{0, 1, 3'b000, 32'h0000_0010, 12'h001, 32'h0000_00AB, 32'h0, 2, 0, 32'h0000_0010, 4'h2, 32'hABAB_ABAB, 0, 32'h0000_F00D};
      vecs[7]  = '{0, 1, 3'b010, 32'hFFFF_FFFC, 12'h008, 32'hCAFE_F00D, 32'h0, 0, 0, 32'h0000_0004, 4'hF, 32'hCAFE_F00D, 0, 32'h0000_F00D};
      vecs[8]  = '{1, 0, 3'b010, 32'h0000_1000, 12'h001, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 0, 32'h0000_F00D};
      vecs[9]  = '{1, 0, 3'b011, 32'h0000_1000, 12'h000, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 0, 32'h0000_F00D};
      vecs[10] = '{0, 1, 3'b100, 32'h0000_1000, 12'h000, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 0, 32'h0000_F00D};
      vecs[11] = '{1, 0, 3'b001, 32'h0000_1000, 12'h003, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 0, 32'h0000_F00D};
      vecs[12] = '{1, 1, 3'b000, 32'h0000_5000, 12'h000, 32'hFFFF_FFFF, 32'hAAAA_AA7F, 0, 0, 32'h0000_5000, 4'h1, 32'h0, 1, 32'h0000_007F};
      vecs[13] = '{1, 0, 3'b010, 32'h0000_6000, 12'h000, 32'h0, 32'h1234_5678, 5, 0, 32'h0000_6000, 4'hF, 32'h0, 1, 32'h1234_5678};
      vecs[14] = '{0, 1, 3'b010, 32'h0000_1002, 12'h000, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 0, 32'h1234_5678};

      rst_n = 1'b0;
      req_valid = 1'b0; load_en = 1'b0; store_en = 1'b0;
      funct3 = '0; rs1_data = '0; imm = '0; store_data = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) step();
      check("reset_ready", {31'd0, req_ready}, 32'd1);
      check("reset_outputs", {mem_req, mem_we, done, wb_en, err, mem_be, 23'd0},
            {32'd0});
      check("reset_load_data", load_data, 32'd0);
      check("reset_addr", mem_addr, 32'd0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

      // Request with neither enable is not accepted
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      check("noen_no_req", {31'd0, mem_req}, 32'd0);
      check("noen_no_done", {31'd0, done}, 32'd0);
      check("noen_ready", {31'd0, req_ready}, 32'd1);

      // rvalid coinciding with grant is ignored; no response then times out
      begin
         exp_t e;
         int k;
         req_valid = 1'b1; load_en = 1'b1; funct3 = 3'b010;
         rs1_data = 32'h0000_7000; imm = 12'h000;
         e.err = 1'b1; e.wb = 1'b0; e.ldata = 32'h1234_5678;
         sb.push_back(e);
         step();
         req_valid = 1'b0; load_en = 1'b0;
         check("to_req", {31'd0, mem_req}, 32'd1);
         mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
         step();
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
         check("to_busy", {31'd0, req_ready}, 32'd0);
         k = 0;
         while (done !== 1'b1 && k < 40) begin
            step();
            k++;
         end
         check("to_wait_cycles", k, 32'd16);
         check("to_idle", {31'd0, req_ready}, 32'd1);
      end

      // Reset during WAIT_RESP clears outputs; a late rvalid is ignored
      req_valid = 1'b1; load_en = 1'b1; funct3 = 3'b010;
      rs1_data = 32'h0000_8000; imm = 12'h000;
      step();
      req_valid = 1'b0; load_en = 1'b0;
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      check("rst_load_data", load_data, 32'd0);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_outputs", {31'd0, mem_req | done | err | wb_en | mem_we}, 32'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      step();
      mem_rvalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("rst_stray_done%0d", c), {31'd0, done}, 32'd0);
         check($sformatf("rst_stray_ldata%0d", c), load_data, 32'd0);
         step();
      end

      // Recovery transaction after reset
      begin
         vec_t r;
         r = '{1, 0, 3'b000, 32'h0000_9000, 12'h002, 32'h0, 32'h00C3_0000, 0, 0, 32'h0000_9000, 4'h4, 32'h0, 1, 32'hFFFF_FFC3};
         run_vec(r, 99);
      end
      step();
      check("sb_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test, want completion");
      $fatal(1, "timeout");
   end

endmodule
